alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder, together with its jump-register flag.
- Performs the selected operation on two 32-bit operands and returns the result with valid/ready handshakes on both sides.
- Logic and arithmetic ops complete in one cycle; shifts run iteratively in a sub-module, so issue stalls on `o_con_Ready`.
- Sits between register-read/operand-mux and the EX/MEM register.

Parameters:
- `WIDTH`, 32, operand/result width.
- `SHIFT_STEP`, 1, bit positions shifted per iteration cycle (1, 2, 4, 8 or 16).

Ports:
- `i_clk` input 1 — clock, rising edge.
- `i_rst` input 1 — synchronous active-high reset.
- `i_con_Valid` input 1 — request valid.
- `o_con_Ready` output 1 — unit can accept a request this cycle.
- `i_con_AluCtrl` input 4 — operation code.
- `i_con_JumpReg` input 1 — jump-register flag from the control decoder.
- `i_dat_A` input WIDTH — operand A (rs, or link PC for jal).
- `i_dat_B` input WIDTH — operand B (rt or immediate).
- `i_dat_Shamt` input 5 — shift amount.
- `o_con_Valid` output 1 — result valid.
- `i_con_Ready` input 1 — downstream accepts result.
- `o_dat_Result` output WIDTH — result.
- `o_con_Zero` output 1 — result equals 0.
- `o_con_JumpReg` output 1 — registered copy of `i_con_JumpReg`.
- `o_con_Illegal` output 1 — undefined code was issued.

Behaviour:
- Opcodes:
  - 0: A&B
  - 1: A|B
  - 2: A+B
  - 3: B<<Shamt
  - 4: B>>Shamt (logical)
  - 5: A-B (bne compare)
  - 6: A-B
  - 7: signed(A)<signed(B) ? 1 : 0
  - 8: {B[15:0],16'b0}
  - 9: A (jal link pass)
  - 12: ~(A|B)
  - 13: A^B
  - 14: A (jr target pass)
  - 10, 11, 15: illegal; result 0 and `o_con_Illegal` = 1.
- Arithmetic is modulo 2^WIDTH. No overflow trap. Carry is discarded.
- `o_con_Zero` = (`o_dat_Result` == 0), valid whenever `o_con_Valid` = 1.
- States:
  - IDLE: `o_con_Ready` = 1. On `i_con_Valid`, latch all inputs.
    - Opcode 3/4 with Shamt ≠ 0 → SHIFT.
    - Otherwise compute the result and go to DONE.
  - SHIFT: each cycle shift by min(`SHIFT_STEP`, remaining) and decrement the remaining count. When remaining reaches 0 → DONE. `o_con_Ready` = 0.
  - DONE: `o_con_Valid` = 1; outputs are held stable until `i_con_Ready`.
    - On `i_con_Ready` with no new request → IDLE.
    - `o_con_Ready` = `i_con_Ready` in DONE, so a request presented in the same cycle is accepted (back-to-back issue, no bubble).
- Latency (accept edge → `o_con_Valid` high):
  - Non-shift ops, and shifts with Shamt = 0: 1 cycle.
  - Shifts: 1 + ceil(Shamt / `SHIFT_STEP`) cycles.
- Throughput: one non-shift op per cycle when downstream is always ready.
- Backpressure: `o_dat_Result`, `o_con_Zero`, `o_con_JumpReg` and `o_con_Illegal` do not change while `o_con_Valid` = 1 and `i_con_Ready` = 0.
- Input changes while not accepted are ignored.
- Reset:
  - State → IDLE; `o_con_Valid`, `o_dat_Result`, `o_con_Zero`, `o_con_JumpReg`, `o_con_Illegal` → 0; `o_con_Ready` → 1 on the first cycle after reset.
  - Reset during SHIFT or DONE discards the operation; no result is emitted.
- `i_con_JumpReg` is passed through with the result only. It does not alter the operation; opcode 14 already selects A.
- `o_con_Illegal` does not stall the unit. The result completes normally with value 0.

Decomposition:
- Package `alu_pkg` holds:
  - `alu_op_e`, a 4-bit enum with values AND=0, OR=1, ADD=2, SLL=3, SRL=4, BNE=5, SUB=6, SLT=7, LUI=8, JAL=9, NOR=12, XOR=13, JR=14, INV=15.
  - `alu_state_e` (IDLE, SHIFT, DONE).
  - Constant `ALU_W` = 32.
- Sub-module `alu_iter_shifter` contains the shift register, remaining-count counter and direction bit.
  - Inputs: start, dir, value, amount.
  - Outputs: busy, done, value.
  - It is parameterised by `SHIFT_STEP`.

Test Plan:
- After reset, issue ADD with A=32'h7FFFFFFF, B=1 → next cycle `o_con_Valid`=1, Result=32'h80000000, Zero=0; then SUB with A=B=5 → Result=0, Zero=1.
- SLL with B=1, Shamt=31, `SHIFT_STEP`=1 → `o_con_Ready`=0 for 31 cycles, Valid on cycle 32, Result=32'h80000000. Repeat with `SHIFT_STEP`=4 → Valid on cycle 9.
- SLT with A=32'hFFFFFFFF (−1), B=1 → Result=1. LUI with B=32'h00001234 → Result=32'h12340000. NOR with A=B=0 → Result=32'hFFFFFFFF.
- Hold `i_con_Ready`=0 for 5 cycles after XOR with A=32'hF0F0F0F0, B=32'hFF00FF00 → Result stays 32'h0FF00FF0. Issue a back-to-back request on the release cycle → it is accepted, and its result appears in the next cycle.
- JR with A=32'h00400020 and JumpReg=1 → Result=32'h00400020, `o_con_JumpReg`=1. Opcode 15 → Result=0, Zero=1, Illegal=1.
- Start SRL with Shamt=20, assert `i_rst` on the 3rd shift cycle → no `o_con_Valid` pulse, all outputs 0, `o_con_Ready`=1 on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU execution unit
//   alu_op_e    : 4-bit operation code from the ALU control decoder
//   alu_state_e : issue/iterate/hold states of the execution unit
//   ALU_W       : default operand/result width
package alu_pkg;
    localparam int ALU_W = 32;
    typedef enum logic [3:0] {
        AND = 4'd0, OR = 4'd1, ADD = 4'd2, SLL = 4'd3, SRL = 4'd4, BNE = 4'd5,
        SUB = 4'd6, SLT = 4'd7, LUI = 4'd8, JAL = 4'd9, NOR = 4'd12, XOR = 4'd13,
        JR = 4'd14, INV = 4'd15
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
    // Only non-zero shifts go through the iterative shifter.
    function automatic logic needs_iter(input logic [3:0] op, input logic [4:0] shamt);
        return (op == SLL || op == SRL) && shamt != 5'd0;
    endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/result handshake bundle of the ALU execution unit
//   request : i_con_Valid/o_con_Ready, i_con_AluCtrl, i_con_JumpReg, i_dat_A, i_dat_B, i_dat_Shamt
//   result  : o_con_Valid/i_con_Ready, o_dat_Result, o_con_Zero, o_con_JumpReg, o_con_Illegal
//   slave   : the execution unit; master : the issuing/consuming side
interface alu_exec_unit_if import alu_pkg::*; #(parameter int WIDTH = ALU_W);
    logic             i_con_Valid;
    logic             o_con_Ready;
    logic [3:0]       i_con_AluCtrl;
    logic             i_con_JumpReg;
    logic [WIDTH-1:0] i_dat_A;
    logic [WIDTH-1:0] i_dat_B;
    logic [4:0]       i_dat_Shamt;
    logic             o_con_Valid;
    logic             i_con_Ready;
    logic [WIDTH-1:0] o_dat_Result;
    logic             o_con_Zero;
    logic             o_con_JumpReg;
    logic             o_con_Illegal;
    modport slave (
        input  i_con_Valid, i_con_AluCtrl, i_con_JumpReg, i_dat_A, i_dat_B, i_dat_Shamt, i_con_Ready,
        output o_con_Ready, o_con_Valid, o_dat_Result, o_con_Zero, o_con_JumpReg, o_con_Illegal
    );
    modport master (
        output i_con_Valid, i_con_AluCtrl, i_con_JumpReg, i_dat_A, i_dat_B, i_dat_Shamt, i_con_Ready,
        input  o_con_Ready, o_con_Valid, o_dat_Result, o_con_Zero, o_con_JumpReg, o_con_Illegal
    );
endinterface

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: iterative logical shifter, up to SHIFT_STEP positions per cycle
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : load i_value/i_amount/i_dir (i_amount must be non-zero)
//   i_dir        : 0 = left, 1 = right (logical)
//   o_busy       : shift in progress
//   o_done       : the current cycle performs the final step
//   o_value      : value after this cycle's step
module alu_iter_shifter import alu_pkg::*; #(
    parameter int WIDTH      = ALU_W,
    parameter int SHIFT_STEP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_value,
    input  logic [4:0]       i_amount,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_value
);
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);
    logic [WIDTH-1:0] r_val;
    logic [4:0]       r_rem;
    logic             r_dir;
    logic [4:0]       w_amt;
    assign w_amt   = r_rem < STEP ? r_rem : STEP;
    // o_value is the post-step value so the owner can capture it on the last step.
    assign o_value = r_dir ? r_val >> w_amt : r_val << w_amt;
    assign o_busy  = r_rem != 5'd0;
    assign o_done  = o_busy && r_rem <= STEP;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val <= '0;
            r_rem <= '0;
            r_dir <= 1'b0;
        end else if (i_start) begin
            r_val <= i_value;
            r_rem <= i_amount;
            r_dir <= i_dir;
        end else if (o_busy) begin
            r_val <= o_value;
            r_rem <= r_rem - w_amt;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes one ALU control code on two operands with valid/ready on both sides
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : request (valid/ready, code, jump-register flag, A, B, shamt) and
//                  result (valid/ready, result, zero, jump-register copy, illegal)
module alu_exec_unit import alu_pkg::*; #(
    parameter int WIDTH      = ALU_W,
    parameter int SHIFT_STEP = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_exec_unit_if.slave bus
);
    alu_state_e       r_state, w_state_n;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_jr, r_illegal;
    logic [WIDTH-1:0] w_calc, w_shift_val;
    logic             w_illegal, w_accept, w_iter, w_busy, w_done, w_shift_end;
    assign bus.o_con_Ready   = r_state == IDLE || (r_state == DONE && bus.i_con_Ready);
    assign bus.o_con_Valid   = r_state == DONE;
    assign bus.o_dat_Result  = r_result;
    assign bus.o_con_Zero    = r_zero;
    assign bus.o_con_JumpReg = r_jr;
    assign bus.o_con_Illegal = r_illegal;
    assign w_accept    = bus.i_con_Valid && bus.o_con_Ready;
    assign w_iter      = needs_iter(bus.i_con_AluCtrl, bus.i_dat_Shamt);
    assign w_shift_end = r_state == SHIFT && (w_done || !w_busy);
    always_comb begin
        w_calc    = '0;
        w_illegal = 1'b0;
        case (alu_op_e'(bus.i_con_AluCtrl))
            AND:      w_calc = bus.i_dat_A & bus.i_dat_B;
            OR:       w_calc = bus.i_dat_A | bus.i_dat_B;
            ADD:      w_calc = bus.i_dat_A + bus.i_dat_B;
            SLL, SRL: w_calc = bus.i_dat_B;
            BNE, SUB: w_calc = bus.i_dat_A - bus.i_dat_B;
            SLT:      w_calc = {{(WIDTH-1){1'b0}}, $signed(bus.i_dat_A) < $signed(bus.i_dat_B)};
            LUI:      w_calc = bus.i_dat_B << 16;
            JAL, JR:  w_calc = bus.i_dat_A;
            NOR:      w_calc = ~(bus.i_dat_A | bus.i_dat_B);
            XOR:      w_calc = bus.i_dat_A ^ bus.i_dat_B;
            default:  w_illegal = 1'b1;
        endcase
    end
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            SHIFT:   w_state_n = w_shift_end ? DONE : SHIFT;
            DONE:    w_state_n = w_accept ? (w_iter ? SHIFT : DONE) : (bus.i_con_Ready ? IDLE : DONE);
            default: w_state_n = w_accept ? (w_iter ? SHIFT : DONE) : IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_n;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_jr      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_jr      <= bus.i_con_JumpReg;
            r_illegal <= w_illegal;
            if (!w_iter) begin
                r_result <= w_calc;
                r_zero   <= w_calc == '0;
            end
        end else if (w_shift_end) begin
            r_result <= w_shift_val;
            r_zero   <= w_shift_val == '0;
        end
    end
    alu_iter_shifter #(.WIDTH(WIDTH), .SHIFT_STEP(SHIFT_STEP)) u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_accept && w_iter),
        .i_dir   (bus.i_con_AluCtrl == SRL),
        .i_value (bus.i_dat_B),
        .i_amount(bus.i_dat_Shamt),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_value (w_shift_val)
    );
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven and scoreboarded check of alu_exec_unit
module tb_alu_exec_unit;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit_if #(.WIDTH(32)) bus4 ();
    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(1)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        j;
        logic        il;
    } exp_t;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        jr;
        logic [31:0] r;
        logic        z;
        logic        il;
    } vec_t;
    exp_t q[$];
    exp_t m_e;
    vec_t tv[16];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return b << sh;
            4'd4: return b >> sh;
            4'd5, 4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return {b[15:0], 16'h0000};
            4'd9, 4'd14: return a;
            4'd12: return ~(a | b);
            4'd13: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction
    // Scoreboard: a result is consumed on every valid&ready handshake.
    always @(negedge clk) begin
        if (!rst && bus.o_con_Valid && bus.i_con_Ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none at %0t", bus.o_dat_Result, $time);
            end else begin
                m_e = q.pop_front();
                chk("result", bus.o_dat_Result, m_e.r);
                chk("zero", {31'd0, bus.o_con_Zero}, {31'd0, m_e.z});
                chk("jumpreg", {31'd0, bus.o_con_JumpReg}, {31'd0, m_e.j});
                chk("illegal", {31'd0, bus.o_con_Illegal}, {31'd0, m_e.il});
            end
        end
    end
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic jr, input logic push, input exp_t e);
        int n;
        n = 0;
        bus.i_con_Valid   = 1'b1;
        bus.i_con_AluCtrl = op;
        bus.i_dat_A       = a;
        bus.i_dat_B       = b;
        bus.i_dat_Shamt   = sh;
        bus.i_con_JumpReg = jr;
        forever begin
            @(negedge clk);
            if (bus.o_con_Ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout actual=not_ready required=ready at %0t", $time);
                bus.i_con_Valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (push) q.push_back(e);
        #1 bus.i_con_Valid = 1'b0;
    endtask
    task automatic issue_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic jr);
        exp_t e;
        e.r  = model(op, a, b, sh);
        e.z  = e.r == 32'd0;
        e.j  = jr;
        e.il = op == 4'd10 || op == 4'd11 || op == 4'd15;
        issue(op, a, b, sh, jr, 1'b1, e);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.o_con_Valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_bounded", {31'd0, n >= 200}, 32'd0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        int cyc;
        int rl;
        int vp;
        bus.i_con_Valid = 0; bus.i_con_AluCtrl = 0; bus.i_con_JumpReg = 0;
        bus.i_dat_A = 0; bus.i_dat_B = 0; bus.i_dat_Shamt = 0; bus.i_con_Ready = 1;
        bus4.i_con_Valid = 0; bus4.i_con_AluCtrl = 0; bus4.i_con_JumpReg = 0;
        bus4.i_dat_A = 0; bus4.i_dat_B = 0; bus4.i_dat_Shamt = 0; bus4.i_con_Ready = 1;
        tv[0]  = '{ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 32'h80000000, 1'b0, 1'b0};
        tv[1]  = '{SUB, 32'h5, 32'h5, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[2]  = '{SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h1, 1'b0, 1'b0};
        tv[3]  = '{LUI, 32'h0, 32'h00001234, 5'd0, 1'b0, 32'h12340000, 1'b0, 1'b0};
        tv[4]  = '{NOR, 32'h0, 32'h0, 5'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tv[5]  = '{JR, 32'h00400020, 32'h0, 5'd0, 1'b1, 32'h00400020, 1'b0, 1'b0};
        tv[6]  = '{INV, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[7]  = '{AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0, 32'hF000F000, 1'b0, 1'b0};
        tv[8]  = '{OR, 32'h0F0F0000, 32'h000000F0, 5'd0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0};
        tv[9]  = '{BNE, 32'hA, 32'h3, 5'd0, 1'b0, 32'h7, 1'b0, 1'b0};
        tv[10] = '{JAL, 32'h8, 32'hFFFF, 5'd0, 1'b1, 32'h8, 1'b0, 1'b0};
        tv[11] = '{SLL, 32'h0, 32'h3, 5'd0, 1'b0, 32'h3, 1'b0, 1'b0};
        tv[12] = '{SRL, 32'h0, 32'h80000000, 5'd4, 1'b0, 32'h08000000, 1'b0, 1'b0};
        tv[13] = '{4'd10, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[14] = '{SLT, 32'h1, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[15] = '{SUB, 32'h0, 32'h1, 5'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", {31'd0, bus.o_con_Valid}, 32'd0);
        chk("rst_ready", {31'd0, bus.o_con_Ready}, 32'd1);
        chk("rst_result", bus.o_dat_Result, 32'd0);
        chk("rst_flags", {29'd0, bus.o_con_Zero, bus.o_con_JumpReg, bus.o_con_Illegal}, 32'd0);
        // First ADD: valid must be up right after the accept edge.
        issue(ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b0, 1'b0});
        chk("add_latency", {31'd0, bus.o_con_Valid}, 32'd1);
        for (int i = 0; i < 16; i++)
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].sh, tv[i].jr, 1'b1, '{tv[i].r, tv[i].z, tv[i].jr, tv[i].il});
        drain();
        for (int i = 0; i < 24; i++)
            issue_model(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        drain();
        // SLL by 31 with one position per cycle.
        issue(SLL, 32'h0, 32'h1, 5'd31, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b0, 1'b0});
        cyc = 1;
        rl = 0;
        while (!bus.o_con_Valid && cyc < 100) begin
            if (!bus.o_con_Ready) rl++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("sll31_latency", cyc, 32);
        chk("sll31_ready_low", rl, 31);
        drain();
        // Same shift on the four-positions-per-cycle instance.
        bus4.i_con_Valid = 1'b1; bus4.i_con_AluCtrl = SLL; bus4.i_dat_B = 32'h1; bus4.i_dat_Shamt = 5'd31;
        @(posedge clk);
        #1 bus4.i_con_Valid = 1'b0;
        cyc = 1;
        while (!bus4.o_con_Valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("step4_latency", cyc, 9);
        chk("step4_result", bus4.o_dat_Result, 32'h80000000);
        // Backpressure hold, then back-to-back issue on the release cycle.
        bus.i_con_Ready = 1'b0;
        issue(XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0, 1'b1, '{32'h0FF00FF0, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {31'd0, bus.o_con_Valid}, 32'd1);
            chk("hold_result", bus.o_dat_Result, 32'h0FF00FF0);
            @(posedge clk);
            #1;
        end
        bus.i_con_Ready = 1'b1;
        issue(ADD, 32'h3, 32'h4, 5'd0, 1'b0, 1'b1, '{32'h7, 1'b0, 1'b0, 1'b0});
        chk("b2b_valid", {31'd0, bus.o_con_Valid}, 32'd1);
        chk("b2b_result", bus.o_dat_Result, 32'h7);
        drain();
        // Reset on the third shift cycle discards the SRL.
        issue(SRL, 32'h0, 32'hFFFFFFFF, 5'd20, 1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("srst_valid", {31'd0, bus.o_con_Valid}, 32'd0);
        chk("srst_ready", {31'd0, bus.o_con_Ready}, 32'd1);
        chk("srst_result", bus.o_dat_Result, 32'd0);
        chk("srst_flags", {29'd0, bus.o_con_Zero, bus.o_con_JumpReg, bus.o_con_Illegal}, 32'd0);
        vp = 0;
        repeat (30) begin
            if (bus.o_con_Valid) vp++;
            @(posedge clk);
            #1;
        end
        chk("srst_no_pulse", vp, 0);
        issue(OR, 32'h00F0, 32'h0F00, 5'd0, 1'b0, 1'b1, '{32'h0FF0, 1'b0, 1'b0, 1'b0});
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
